// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer around a combinational RGB-to-luma unit: valid/ready pixel
// intake, one-deep registered output with position and end-of-line/frame tags.

module grayscale #(
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
    output logic [P_PIXEL_DEPTH-1:0] O_PIXEL
);
    localparam int L_CH_W  = P_PIXEL_DEPTH / 3;
    localparam int L_SUM_W = L_CH_W + 8;

    logic [L_CH_W-1:0]  r_ch;
    logic [L_CH_W-1:0]  g_ch;
    logic [L_CH_W-1:0]  b_ch;
    logic [L_SUM_W-1:0] luma_sum;
    logic [L_CH_W-1:0]  luma;

    assign r_ch = I_PIXEL[3*L_CH_W-1 -: L_CH_W];
    assign g_ch = I_PIXEL[2*L_CH_W-1 -: L_CH_W];
    assign b_ch = I_PIXEL[L_CH_W-1:0];

    // Weights 77/150/29 sum to 256, so the shift by 8 cannot overflow a channel.
    assign luma_sum = L_SUM_W'(r_ch) * L_SUM_W'(77)
                    + L_SUM_W'(g_ch) * L_SUM_W'(150)
                    + L_SUM_W'(b_ch) * L_SUM_W'(29);
    assign luma = L_CH_W'(luma_sum >> 8);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rep
            assign O_PIXEL[gi*L_CH_W +: L_CH_W] = luma;
        end
        if (P_PIXEL_DEPTH > 3*L_CH_W) begin : g_pad
            assign O_PIXEL[P_PIXEL_DEPTH-1:3*L_CH_W] = '0;
        end
    endgenerate
endmodule

module grayscale_frame_ctrl #(
    parameter int P_PIXEL_DEPTH  = 24,
    parameter int P_IMAGE_WIDTH  = 640,
    parameter int P_IMAGE_HEIGHT = 480,
    localparam int L_COL_W = (P_IMAGE_WIDTH  > 1) ? $clog2(P_IMAGE_WIDTH)  : 1,
    localparam int L_ROW_W = (P_IMAGE_HEIGHT > 1) ? $clog2(P_IMAGE_HEIGHT) : 1
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET_N,
    input  logic                     I_START,
    input  logic                     I_ABORT,
    input  logic                     I_IN_VALID,
    output logic                     O_IN_READY,
    input  logic [P_PIXEL_DEPTH-1:0] I_IN_PIXEL,
    output logic                     O_OUT_VALID,
    input  logic                     I_OUT_READY,
    output logic [P_PIXEL_DEPTH-1:0] O_OUT_PIXEL,
    output logic [L_COL_W-1:0]       O_OUT_COL,
    output logic [L_ROW_W-1:0]       O_OUT_ROW,
    output logic                     O_OUT_EOL,
    output logic                     O_OUT_EOF,
    output logic                     O_BUSY,
    output logic                     O_DONE
);
    localparam logic [L_COL_W-1:0] L_COL_LAST = L_COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [L_ROW_W-1:0] L_ROW_LAST = L_ROW_W'(P_IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_reg, state_next;
    logic [L_COL_W-1:0]       col_reg, col_next;
    logic [L_ROW_W-1:0]       row_reg, row_next;
    logic                     out_valid_reg;
    logic [P_PIXEL_DEPTH-1:0] out_pixel_reg;
    logic [L_COL_W-1:0]       out_col_reg;
    logic [L_ROW_W-1:0]       out_row_reg;
    logic                     out_eol_reg;
    logic                     out_eof_reg;

    logic [P_PIXEL_DEPTH-1:0] gray_pixel;
    logic                     accept;
    logic                     out_fire;
    logic                     abort_hit;
    logic                     col_last;
    logic                     frame_last;

    grayscale #(.P_PIXEL_DEPTH(P_PIXEL_DEPTH)) u_gray (
        .I_PIXEL (I_IN_PIXEL),
        .O_PIXEL (gray_pixel)
    );

    assign O_IN_READY = (state_reg == S_RUN) & (~out_valid_reg | I_OUT_READY);
    assign accept     = I_IN_VALID & O_IN_READY;
    assign out_fire   = out_valid_reg & I_OUT_READY;
    assign abort_hit  = I_ABORT & (state_reg != S_IDLE);
    assign col_last   = (col_reg == L_COL_LAST);
    assign frame_last = col_last & (row_reg == L_ROW_LAST);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        case (state_reg)
            S_IDLE:  if (I_START) state_next = S_RUN;
            S_RUN:   if (accept && frame_last) state_next = S_DRAIN;
            S_DRAIN: if (out_fire) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (accept) begin
            if (col_last) begin
                col_next = '0;
                row_next = frame_last ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
        // Abort overrides everything, including an accept in the same cycle.
        if (abort_hit) begin
            state_next = S_IDLE;
            col_next   = '0;
            row_next   = '0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_reg <= S_IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            out_col_reg   <= '0;
            out_row_reg   <= '0;
            out_eol_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
        end else if (abort_hit) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_pixel_reg <= gray_pixel;
            out_col_reg   <= col_reg;
            out_row_reg   <= row_reg;
            out_eol_reg   <= col_last;
            out_eof_reg   <= frame_last;
        end else if (out_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign O_OUT_VALID = out_valid_reg;
    assign O_OUT_PIXEL = out_pixel_reg;
    assign O_OUT_COL   = out_col_reg;
    assign O_OUT_ROW   = out_row_reg;
    assign O_OUT_EOL   = out_eol_reg;
    assign O_OUT_EOF   = out_eof_reg;
    assign O_BUSY      = (state_reg == S_RUN) | (state_reg == S_DRAIN);
    assign O_DONE      = (state_reg == S_DONE);
endmodule
